uart_rx_unit: RTL
=================

Name: uart_rx_unit

Overview:
- 8N1 UART receiver; the input-side counterpart of the processor's serial output path.
- Deserialises a byte from the serial line and presents it zero-extended to DATA_WIDTH.
- Holds a level RX_flag until the control unit acknowledges with RxClear.
- Reports framing-error and overrun status, both sticky until acknowledged.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- DATA_WIDTH, 32, width of RxData. The byte sits in [7:0] and the upper bits are 0.
- Derived localparams:
  - CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer-truncated; 434 at the defaults.
  - HALF_BIT = CLKS_PER_BIT/2; 217 at the defaults.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  reset, asynchronous, active-low.
- SerialDataIn  input  1  asynchronous serial line; idle high.
- RxClear  input  1  one-cycle acknowledge. Clears RX_flag, Overrun and FrameError.
- RxData  output  DATA_WIDTH  last correctly framed byte, zero-extended.
- RX_flag  output  1  new byte available; held until RxClear.
- FrameError  output  1  sticky: a stop bit was sampled as 0.
- Overrun  output  1  sticky: a new byte arrived while RX_flag=1.
- Busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE; all counters 0; shift register 0.
  - Synchroniser flops=1.
  - RxData=0, RX_flag=0, FrameError=0, Overrun=0, Busy=0.
- Synchroniser: SerialDataIn passes through 2 flops to give rx_s. All decisions use rx_s only.
- Counters:
  - baud_cnt counts clock cycles.
  - bit_cnt is 3 bits and counts data bits 0..7.
- States:
  - IDLE: when rx_s==0, go to START with baud_cnt=0.
  - START: count to HALF_BIT-1.
    - At terminal count, rx_s==0: go to DATA with baud_cnt=0, bit_cnt=0.
    - At terminal count, rx_s==1: treat as a glitch and return to IDLE. No flag or status change.
  - DATA: count to CLKS_PER_BIT-1.
    - At terminal count, shift rx_s into the MSB of the 8-bit shift register (LSB-first on the line).
    - If bit_cnt==7, go to STOP; otherwise increment bit_cnt.
    - Reset baud_cnt either way.
  - STOP: count to CLKS_PER_BIT-1, then sample rx_s.
    - rx_s==1 (valid frame): load RxData<={zeros, shift_reg} and set RX_flag=1. Go to IDLE.
    - rx_s==0 (framing error): FrameError<=1; RxData and RX_flag unchanged. Go to BREAK_WAIT.
  - BREAK_WAIT: stay while rx_s==0; go to IDLE when rx_s==1. This prevents a held-low line from retriggering.
- Latency: RX_flag rises on the clock edge that performs the stop-bit sample. That is ~2 + HALF_BIT + 9*CLKS_PER_BIT cycles after the falling edge of the start bit.
- Overrun: set if a valid frame completes while RX_flag==1 and RxClear==0 in that cycle. RxData is overwritten with the new byte.
- Simultaneous events:
  - RxClear in the same cycle as a valid frame completion: RX_flag stays 1, Overrun not set, new data loaded.
  - RxClear in the same cycle as a framing error: FrameError ends at 1 (set wins).
- RxClear does not affect the receive FSM; reception continues uninterrupted.
- Reset mid-frame: immediate abort to IDLE with all outputs at reset values. The remainder of a partial frame is ignored, because the line is high or a later edge starts a fresh frame.

Test Plan:
- Reset value check (defaults): assert reset, then release -> RxData=0x00000000, RX_flag=0, FrameError=0, Overrun=0, Busy=0.
- Valid frame: send 0xA5 (8N1, 434 clk/bit) -> RX_flag=1, RxData=0x000000A5, FrameError=0; Busy low after STOP. One-cycle RxClear -> RX_flag=0 next cycle.
- Glitch rejection: drive line low for 100 cycles (<217), then high -> FSM returns to IDLE, RX_flag=0, RxData unchanged.
- Framing error and recovery:
  - Send 0x3C with stop bit 0, hold line low 2000 cycles -> FrameError=1, RX_flag=0, RxData unchanged, Busy=1 (BREAK_WAIT) until line high.
  - Then send 0x55 -> RxData=0x00000055, RX_flag=1, FrameError still 1 until RxClear.
- Overrun:
  - Send 0x11 then 0x22 with no RxClear -> Overrun=1, RxData=0x00000022.
  - Repeat with RxClear pulsed exactly on the 0x22 stop-sample cycle -> Overrun=0, RX_flag=1.
- Reset mid-frame:
  - Assert reset during data bit 3 of 0xF0 -> all outputs 0, state IDLE.
  - Release and send 0x81 -> RxData=0x00000081, RX_flag=1, no error flags.

Source files
------------

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 8N1 UART receiver.
// Deserialises one byte per frame and presents it zero-extended on RxData.
// RX_flag is held until RxClear. FrameError and Overrun are sticky status
// bits that RxClear also acknowledges.
// The receive FSM samples each bit at mid-bit. It finds mid-bit by timing
// half a bit period from the start-bit edge, then whole bit periods from there.

module uart_rx_unit #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SerialDataIn,
    input  logic                  RxClear,
    output logic [DATA_WIDTH-1:0] RxData,
    output logic                  RX_flag,
    output logic                  FrameError,
    output logic                  Overrun,
    output logic                  Busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CntW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Terminal counts for the half-bit (start) and full-bit (data/stop) intervals.
    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreakWait
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         baud_cnt_q, baud_cnt_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [7:0]              shift_q, shift_d;
    logic                    rx_meta_q, rx_meta_d;
    logic                    rx_s_q, rx_s_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_flag_q, rx_flag_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;

    // Register all state. The synchroniser resets to the idle-line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_data_q   <= '0;
            rx_flag_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            rx_data_q   <= rx_data_d;
            rx_flag_q   <= rx_flag_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic: synchroniser, receive FSM and status flags.
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_meta_d   = SerialDataIn;
        rx_s_d      = rx_meta_q;
        rx_data_d   = rx_data_q;
        rx_flag_d   = rx_flag_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        // The acknowledge is applied first. A frame event in the same cycle
        // then overrides it.
        if (RxClear) begin
            rx_flag_d   = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d    = StStart;
                    baud_cnt_d = '0;
                end
            end

            StStart: begin
                if (baud_cnt_q == HalfLast) begin
                    baud_cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        // The line went high again before mid-start-bit, so
                        // this was a glitch rather than a start bit.
                        state_d = StIdle;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CntW'(1);
                end
            end

            StData: begin
                if (baud_cnt_q == BitLast) begin
                    baud_cnt_d = '0;
                    // The line sends the LSB first, so each bit shifts in at
                    // the top of the register.
                    shift_d    = {rx_s_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CntW'(1);
                end
            end

            StStop: begin
                if (baud_cnt_q == BitLast) begin
                    baud_cnt_d = '0;
                    if (rx_s_q) begin
                        state_d   = StIdle;
                        rx_data_d = {{(DATA_WIDTH - 8){1'b0}}, shift_q};
                        rx_flag_d = 1'b1;
                        // A same-cycle acknowledge consumes the old byte, so
                        // that case is not an overrun.
                        if (rx_flag_q && !RxClear) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        state_d     = StBreakWait;
                        frame_err_d = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CntW'(1);
                end
            end

            StBreakWait: begin
                // Wait here while the line is held low, so a break does not
                // start another frame.
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign RxData     = rx_data_q;
    assign RX_flag    = rx_flag_q;
    assign FrameError = frame_err_q;
    assign Overrun    = overrun_q;
    assign Busy       = (state_q != StIdle);

endmodule
